gfx_accelerator: RTL and testbench
==================================

# gfx_accelerator

Parametrised 2D drawing engine: accepts one draw command per handshake from the CPU-side MMIO block and emits framebuffer pixel writes to the arbiter, one pixel per accepted write cycle. Supports Bresenham lines in all octants and axis-aligned filled rectangles, with a configurable color depth. Writes are flow-controlled by the arbiter through `XL_wr_ready`. Off-screen pixels are clipped.

## Interface

Parameters:
- `pixel_width`, 1024: framebuffer width in pixels.
- `pixel_height`, 768: framebuffer height in pixels.
- `pixel_width_bits`, `log2(pixel_width)`: x coordinate width.
- `pixel_height_bits`, `log2(pixel_height)`: y coordinate width.
- `color_bits`, 8: color width; equals the framebuffer word width.
- `mem_depth`, `pixel_width*pixel_height`: framebuffer word count.
- `mem_addr_width`, `log2(mem_depth)`: write address width.

Ports:
- `clk` in, 1: the single clock.
- `rst_n` in, 1: asynchronous, active-low reset.
- `x0`, `x1` in, `pixel_width_bits`: x endpoints, or rectangle corners.
- `y0`, `y1` in, `pixel_height_bits`: y endpoints, or rectangle corners.
- `color` in, `color_bits`: pixel value.
- `mode` in, 1: 0 = line, 1 = filled rectangle.
- `RX_valid` in, 1: command valid.
- `RX_ready` out, 1: engine idle and able to accept a command.
- `done` out, 1: one-cycle pulse after the last pixel of a command is accepted.
- `XL_wr_en` out, 1: pixel write valid.
- `XL_wr_ready` in, 1: arbiter accepts the write this cycle.
- `XL_wr_data` out, `color_bits`: pixel color.
- `XL_wr_addr` out, `mem_addr_width`: `y*pixel_width + x`, truncated to `mem_addr_width`.

## Operation

**States:** IDLE, SETUP, LINE, RECT.

**IDLE**
- `RX_ready=1`.
- On `RX_valid && RX_ready`, latch all command inputs, including `color` and `mode`, then go to SETUP.

**SETUP (one cycle)**
- Line mode:
  - `steep = |y1-y0| > |x1-x0|`. If `steep`, swap x and y of both endpoints.
  - If `x0 > x1`, swap the endpoints.
  - `dx = x1-x0`, `dy = |y1-y0|`, `ystep = (y0<y1) ? +1 : -1`.
  - `err = -(dx>>1)`, held in a signed register of `max(pixel_width_bits, pixel_height_bits)+2` bits.
  - Go to LINE.
- Rectangle mode:
  - `xs=min(x0,x1)`, `xe=max(x0,x1)`, `ys=min(y0,y1)`, `ye=max(y0,y1)`.
  - Cursor starts at `(xs,ys)`. Go to RECT.

**LINE**
- Present the current pixel. It is `(y,x)` if `steep`, otherwise `(x,y)`.
- On advance: `err += dy`. If `err > 0`, then `y += ystep` and `err -= dx`. Then `x += 1`.
- After the pixel with `x == x1` advances, go to IDLE.
- Zero-length line (`x0==x1`, `y0==y1`): exactly one pixel.

**RECT**
- Row-major walk: x runs `xs..xe` within a row, then y increments and x reloads `xs`.
- After pixel `(xe,ye)` advances, go to IDLE.
- Total writes = `(xe-xs+1)*(ye-ys+1)`, minus clipped pixels.

**Advance condition**
- The current pixel advances when `XL_wr_en && XL_wr_ready`, or when the current pixel is clipped.

**Clipping**
- A pixel is clipped if `x >= pixel_width` or `y >= pixel_height`.
- A clipped pixel has `XL_wr_en=0` for its cycle and advances unconditionally.

**Output stability**
- `XL_wr_addr` and `XL_wr_data` are valid whenever `XL_wr_en=1`.
- While `XL_wr_en=1 && !XL_wr_ready`, all write outputs hold stable.

**Done and commands**
- `done` pulses in the cycle the engine re-enters IDLE.
- `RX_valid` while busy is ignored. Commands are never queued.

## Timing

**Reset** (`rst_n` low, asynchronous):
- State goes to IDLE.
- `RX_ready=0`, `XL_wr_en=0`, `XL_wr_data=0`, `XL_wr_addr=0`, `done=0`.
- `RX_ready` rises at the first clock edge after `rst_n` deasserts.

**Latency:**
- Command accepted at edge N.
- SETUP occupies cycle N+1.
- First pixel (`XL_wr_en=1`) is presented in cycle N+2.

**Throughput:** one pixel per cycle while `XL_wr_ready=1`.

**Completion:**
- Last write accepted at edge M.
- `done=1` and `RX_ready=1` in cycle M+1.
- Earliest next-command accept is edge M+1.

**Reset mid-command:**
- The command is abandoned immediately.
- No further writes and no `done` pulse.

**Address arithmetic:**
- Either combinational, or registered with the pixel.
- Either way it must meet the first-pixel latency above.

## Test plan

- **Horizontal line:** line (0,0)->(3,0), color 5, `XL_wr_ready=1` -> addresses 0,1,2,3 on consecutive cycles, data 5. First write 2 cycles after accept. `done` pulses once.
- **Shallow line:** line (0,0)->(4,2) -> pixels (0,0),(1,0),(2,1),(3,1),(4,2), i.e. addresses 0,1,1026,1027,2052.
- **Reversed steep line:** line (2,4)->(2,1) -> 4 writes with addresses 1026,2050,3074,4098 in that order. `RX_valid` asserted mid-line is ignored.
- **Rectangle with backpressure:** rect (2,2)->(1,1), `XL_wr_ready` toggling every cycle -> addresses 1025,1026,2049,2050. Outputs held stable across stalls. Exactly 4 accepted writes.
- **Clipping:** line (1022,0)->(1025,0) with `pixel_width=1024` -> writes only at 1022 and 1023. `done` pulses after the 4th pixel slot.
- **Reset mid-command:** `rst_n` pulsed low during a rectangle fill -> outputs 0 immediately. `RX_ready=1` one edge after release. The next command executes correctly.

Source files
------------

// File: rtl/gfx_accelerator.sv
// gfx_accelerator: 2D drawing engine producing framebuffer pixel writes.
//   Draws Bresenham lines in every octant (mode=0) or axis-aligned filled
//   rectangles (mode=1). Pixels outside the framebuffer are clipped: they
//   take one slot with XL_wr_en low and no write is issued for them.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   x0,y0,x1,y1,color,mode  draw command, latched on RX_valid && RX_ready
//   RX_valid / RX_ready     command handshake (ready only when idle)
//   done                    one-cycle pulse when a command has finished
//   XL_wr_en / XL_wr_ready  pixel write handshake towards the arbiter
//   XL_wr_data, XL_wr_addr  pixel color and address y*pixel_width + x
module gfx_accelerator #(
    parameter int unsigned pixel_width       = 1024,
    parameter int unsigned pixel_height      = 768,
    parameter int unsigned pixel_width_bits  = $clog2(pixel_width),
    parameter int unsigned pixel_height_bits = $clog2(pixel_height),
    parameter int unsigned color_bits        = 8,
    parameter int unsigned mem_depth         = pixel_width * pixel_height,
    parameter int unsigned mem_addr_width    = $clog2(mem_depth)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [pixel_width_bits-1:0]  x0,
    input  logic [pixel_width_bits-1:0]  x1,
    input  logic [pixel_height_bits-1:0] y0,
    input  logic [pixel_height_bits-1:0] y1,
    input  logic [color_bits-1:0]        color,
    input  logic                         mode,
    input  logic                         RX_valid,
    output logic                         RX_ready,
    output logic                         done,
    output logic                         XL_wr_en,
    input  logic                         XL_wr_ready,
    output logic [color_bits-1:0]        XL_wr_data,
    output logic [mem_addr_width-1:0]    XL_wr_addr
);

    // Cursor width covers either axis, since a steep line swaps x and y.
    localparam int unsigned CW = (pixel_width_bits > pixel_height_bits) ?
                                 pixel_width_bits : pixel_height_bits;
    localparam int unsigned EW = CW + 2;
    localparam int unsigned AW = mem_addr_width;

    typedef enum logic [1:0] {IDLE, SETUP, LINE, RECT} state_t;

    state_t                 state_q, state_d;
    logic                   armed_q, armed_d;
    logic                   done_q, done_d;
    logic                   mode_q, mode_d;
    logic [color_bits-1:0]  color_q, color_d;
    logic [CW-1:0]          lx0_q, lx0_d, lx1_q, lx1_d;
    logic [CW-1:0]          ly0_q, ly0_d, ly1_q, ly1_d;
    logic [CW-1:0]          cx_q, cx_d, cy_q, cy_d;
    logic [CW-1:0]          xs_q, xs_d, xe_q, xe_d, ye_q, ye_d;
    logic [CW-1:0]          dx_q, dx_d, dy_q, dy_d;
    logic signed [EW-1:0]   err_q, err_d;
    logic                   ystep_up_q, ystep_up_d;
    logic                   steep_q, steep_d;

    // Line setup terms, derived from the latched command.
    logic [CW-1:0]          adx, ady, a0, a1, b0, b1;
    logic [CW-1:0]          s_a0, s_a1, s_b0, s_b1, s_dx, s_dy;
    logic                   s_steep, s_up;
    logic signed [EW-1:0]   s_err;

    // Current pixel and write-side signals.
    logic [CW-1:0]          px, py;
    logic                   active, clip, adv;
    logic signed [EW-1:0]   err_sum;
    logic [AW-1:0]          addr_calc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
            mode_q     <= 1'b0;
            color_q    <= '0;
            lx0_q      <= '0;
            lx1_q      <= '0;
            ly0_q      <= '0;
            ly1_q      <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            xs_q       <= '0;
            xe_q       <= '0;
            ye_q       <= '0;
            dx_q       <= '0;
            dy_q       <= '0;
            err_q      <= '0;
            ystep_up_q <= 1'b0;
            steep_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
            mode_q     <= mode_d;
            color_q    <= color_d;
            lx0_q      <= lx0_d;
            lx1_q      <= lx1_d;
            ly0_q      <= ly0_d;
            ly1_q      <= ly1_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            xs_q       <= xs_d;
            xe_q       <= xe_d;
            ye_q       <= ye_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            err_q      <= err_d;
            ystep_up_q <= ystep_up_d;
            steep_q    <= steep_d;
        end
    end

    // Bresenham setup: swap axes for steep lines, then order by major axis.
    always_comb begin
        adx     = (lx0_q > lx1_q) ? lx0_q - lx1_q : lx1_q - lx0_q;
        ady     = (ly0_q > ly1_q) ? ly0_q - ly1_q : ly1_q - ly0_q;
        s_steep = ady > adx;
        a0      = s_steep ? ly0_q : lx0_q;
        a1      = s_steep ? ly1_q : lx1_q;
        b0      = s_steep ? lx0_q : ly0_q;
        b1      = s_steep ? lx1_q : ly1_q;
        if (a0 > a1) begin
            s_a0 = a1;
            s_a1 = a0;
            s_b0 = b1;
            s_b1 = b0;
        end else begin
            s_a0 = a0;
            s_a1 = a1;
            s_b0 = b0;
            s_b1 = b1;
        end
        s_dx  = s_a1 - s_a0;
        s_dy  = (s_b1 > s_b0) ? s_b1 - s_b0 : s_b0 - s_b1;
        s_up  = s_b0 < s_b1;
        s_err = -$signed({2'b00, s_dx >> 1});
    end

    // Write side is decoded from registered state only, so it holds still
    // across stalls and drops to zero as soon as reset is asserted.
    always_comb begin
        active    = (state_q == LINE) || (state_q == RECT);
        px        = steep_q ? cy_q : cx_q;
        py        = steep_q ? cx_q : cy_q;
        clip      = (32'(px) >= pixel_width) || (32'(py) >= pixel_height);
        adv       = active && (clip || XL_wr_ready);
        addr_calc = AW'(py) * AW'(pixel_width) + AW'(px);
        err_sum   = err_q + $signed({2'b00, dy_q});
    end

    assign RX_ready   = armed_q && (state_q == IDLE);
    assign done       = done_q;
    assign XL_wr_en   = active && !clip;
    assign XL_wr_data = active ? color_q : '0;
    assign XL_wr_addr = active ? addr_calc : '0;

    always_comb begin
        state_d    = state_q;
        armed_d    = 1'b1;
        done_d     = 1'b0;
        mode_d     = mode_q;
        color_d    = color_q;
        lx0_d      = lx0_q;
        lx1_d      = lx1_q;
        ly0_d      = ly0_q;
        ly1_d      = ly1_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        xs_d       = xs_q;
        xe_d       = xe_q;
        ye_d       = ye_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        err_d      = err_q;
        ystep_up_d = ystep_up_q;
        steep_d    = steep_q;

        unique case (state_q)
            IDLE: begin
                if (RX_valid && RX_ready) begin
                    lx0_d   = CW'(x0);
                    lx1_d   = CW'(x1);
                    ly0_d   = CW'(y0);
                    ly1_d   = CW'(y1);
                    color_d = color;
                    mode_d  = mode;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (mode_q) begin
                    xs_d    = (lx0_q < lx1_q) ? lx0_q : lx1_q;
                    xe_d    = (lx0_q < lx1_q) ? lx1_q : lx0_q;
                    cy_d    = (ly0_q < ly1_q) ? ly0_q : ly1_q;
                    ye_d    = (ly0_q < ly1_q) ? ly1_q : ly0_q;
                    cx_d    = (lx0_q < lx1_q) ? lx0_q : lx1_q;
                    steep_d = 1'b0;
                    state_d = RECT;
                end else begin
                    // Cursor x is the major axis; xe holds its final value.
                    cx_d       = s_a0;
                    xe_d       = s_a1;
                    cy_d       = s_b0;
                    dx_d       = s_dx;
                    dy_d       = s_dy;
                    ystep_up_d = s_up;
                    err_d      = s_err;
                    steep_d    = s_steep;
                    state_d    = LINE;
                end
            end
            LINE: begin
                if (adv) begin
                    if (cx_q == xe_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                        if (!err_sum[EW-1] && (err_sum != '0)) begin
                            cy_d  = ystep_up_q ? cy_q + 1'b1 : cy_q - 1'b1;
                            err_d = err_sum - $signed({2'b00, dx_q});
                        end else begin
                            err_d = err_sum;
                        end
                    end
                end
            end
            RECT: begin
                if (adv) begin
                    if (cx_q == xe_q) begin
                        if (cy_q == ye_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cy_d = cy_q + 1'b1;
                            cx_d = xs_q;
                        end
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gfx_accelerator.sv
// tb_gfx_accelerator: self-checking bench for gfx_accelerator.
//   A reference model expands each command into its list of pixel slots
//   (address plus clipped flag) with plain integer arithmetic; the bench then
//   walks that list cycle by cycle against the DUT's write port under
//   several XL_wr_ready patterns. x is widened to 11 bits so that
//   off-screen x coordinates can be commanded.
module tb_gfx_accelerator;

    localparam int unsigned PW = 1024;
    localparam int unsigned PH = 768;
    localparam int unsigned XB = 11;
    localparam int unsigned YB = 10;
    localparam int unsigned CB = 8;
    localparam int unsigned AW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [XB-1:0] x0 = '0, x1 = '0;
    logic [YB-1:0] y0 = '0, y1 = '0;
    logic [CB-1:0] color = '0;
    logic          mode = 1'b0;
    logic          RX_valid = 1'b0;
    logic          RX_ready;
    logic          done;
    logic          XL_wr_en;
    logic          XL_wr_ready = 1'b0;
    logic [CB-1:0] XL_wr_data;
    logic [AW-1:0] XL_wr_addr;

    int n_cmp = 0;
    int n_bad = 0;

    int exp_addr[$];
    bit exp_clip[$];

    gfx_accelerator #(
        .pixel_width      (PW),
        .pixel_height     (PH),
        .pixel_width_bits (XB),
        .pixel_height_bits(YB),
        .color_bits       (CB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .color      (color),
        .mode       (mode),
        .RX_valid   (RX_valid),
        .RX_ready   (RX_ready),
        .done       (done),
        .XL_wr_en   (XL_wr_en),
        .XL_wr_ready(XL_wr_ready),
        .XL_wr_data (XL_wr_data),
        .XL_wr_addr (XL_wr_addr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic push_pixel(input int px, input int py);
        exp_clip.push_back((px >= int'(PW)) || (py >= int'(PH)));
        exp_addr.push_back((py * int'(PW) + px) & ((1 << AW) - 1));
    endtask

    // Reference: textbook Bresenham / row-major fill over integer coordinates.
    task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1, input bit m);
        int xa, ya, xb, yb, t, dx, dy, ystep, err, y;
        bit steep;
        exp_addr.delete();
        exp_clip.delete();
        if (m) begin
            for (int yy = (ay0 < ay1 ? ay0 : ay1); yy <= (ay0 < ay1 ? ay1 : ay0); yy++)
                for (int xx = (ax0 < ax1 ? ax0 : ax1); xx <= (ax0 < ax1 ? ax1 : ax0); xx++)
                    push_pixel(xx, yy);
        end else begin
            xa = ax0; ya = ay0; xb = ax1; yb = ay1;
            steep = iabs(yb - ya) > iabs(xb - xa);
            if (steep) begin
                t = xa; xa = ya; ya = t;
                t = xb; xb = yb; yb = t;
            end
            if (xa > xb) begin
                t = xa; xa = xb; xb = t;
                t = ya; ya = yb; yb = t;
            end
            dx = xb - xa;
            dy = iabs(yb - ya);
            ystep = (ya < yb) ? 1 : -1;
            err = -(dx / 2);
            y = ya;
            for (int x = xa; x <= xb; x++) begin
                if (steep) push_pixel(y, x);
                else       push_pixel(x, y);
                err += dy;
                if (err > 0) begin
                    y += ystep;
                    err -= dx;
                end
            end
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the SETUP cycle.
    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int col, input bit m);
        int guard = 0;
        while (RX_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_val("rx_ready_idle", RX_ready, 1);
        x0 = XB'(ax0); y0 = YB'(ay0); x1 = XB'(ax1); y1 = YB'(ay1);
        color = CB'(col);
        mode = m;
        RX_valid = 1'b1;
        @(negedge clk);
        RX_valid = 1'b0;
        check_val("setup_busy", RX_ready, 0);
        check_val("setup_no_wr", XL_wr_en, 0);
    endtask

    // rdy_mode: 0 always ready, 1 toggling, 2 random. poke: spurious RX_valid.
    task automatic run_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int col, input bit m, input int rdy_mode, input bit poke);
        int ptr = 0;
        int cyc = 0;
        bit held = 0;
        logic [AW-1:0] h_addr;
        logic [CB-1:0] h_data;
        bit rdy;
        build_model(ax0, ay0, ax1, ay1, m);
        issue(ax0, ay0, ax1, ay1, col, m);
        while (ptr < exp_addr.size()) begin
            if (cyc > 20000) begin
                check_val("cycle_budget", cyc, 0);
                break;
            end
            @(negedge clk);
            rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
            XL_wr_ready = rdy;
            if (poke) begin
                RX_valid = bit'($urandom_range(0, 1));
                x0 = XB'($urandom); y0 = YB'($urandom);
                color = CB'($urandom);
            end
            check_val("busy_rx_ready", RX_ready, 0);
            check_val("busy_done", done, 0);
            if (exp_clip[ptr]) begin
                check_val("clip_wr_en", XL_wr_en, 0);
                held = 0;
                ptr++;
            end else begin
                check_val("wr_en", XL_wr_en, 1);
                check_val("wr_addr", XL_wr_addr, exp_addr[ptr]);
                check_val("wr_data", XL_wr_data, col & 8'hFF);
                if (held) begin
                    check_val("stall_addr", XL_wr_addr, h_addr);
                    check_val("stall_data", XL_wr_data, h_data);
                end
                held = !rdy;
                h_addr = XL_wr_addr;
                h_data = XL_wr_data;
                if (rdy) ptr++;
            end
            cyc++;
        end
        @(negedge clk);
        RX_valid = 1'b0;
        XL_wr_ready = 1'b1;
        check_val("done_pulse", done, 1);
        check_val("done_rx_ready", RX_ready, 1);
        check_val("done_no_wr", XL_wr_en, 0);
        if (rdy_mode == 0) check_val("done_slot", cyc, exp_addr.size());
        @(negedge clk);
        check_val("done_single", done, 0);
    endtask

    initial begin
        int bx, by, ax0, ay0, ax1, ay1;
        bit m, near_edge;

        // Reset state.
        #2;
        check_val("rst_rx_ready", RX_ready, 0);
        check_val("rst_wr_en", XL_wr_en, 0);
        check_val("rst_wr_data", XL_wr_data, 0);
        check_val("rst_wr_addr", XL_wr_addr, 0);
        check_val("rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rel_rx_ready_low", RX_ready, 0);
        @(negedge clk);
        check_val("rel_rx_ready_high", RX_ready, 1);

        // Directed cases.
        run_cmd(0, 0, 3, 0, 5, 1'b0, 0, 1'b0);      // horizontal
        run_cmd(0, 0, 4, 2, 9, 1'b0, 0, 1'b0);      // shallow
        run_cmd(2, 4, 2, 1, 33, 1'b0, 0, 1'b1);     // reversed steep, RX_valid pokes
        run_cmd(2, 2, 1, 1, 77, 1'b1, 1, 1'b0);     // rect with toggling ready
        run_cmd(1022, 0, 1025, 0, 200, 1'b0, 0, 1'b0); // x clipping
        run_cmd(5, 7, 5, 7, 1, 1'b0, 0, 1'b0);      // zero-length line
        run_cmd(9, 3, 1, 8, 12, 1'b0, 2, 1'b0);     // shallow, descending y
        run_cmd(1020, 765, 1027, 771, 3, 1'b1, 2, 1'b0); // rect straddling corner

        // Reset mid-command.
        issue(0, 0, 9, 9, 7, 1'b1);
        XL_wr_ready = 1'b1;
        repeat (5) @(negedge clk);
        check_val("pre_rst_wr_en", XL_wr_en, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_wr_en", XL_wr_en, 0);
        check_val("mid_rst_wr_addr", XL_wr_addr, 0);
        check_val("mid_rst_wr_data", XL_wr_data, 0);
        check_val("mid_rst_rx_ready", RX_ready, 0);
        check_val("mid_rst_done", done, 0);
        @(negedge clk);
        check_val("mid_rst_hold_done", done, 0);
        rst_n = 1'b1;
        #1;
        check_val("mid_rel_rx_low", RX_ready, 0);
        @(negedge clk);
        check_val("mid_rel_rx_high", RX_ready, 1);
        check_val("mid_rel_no_done", done, 0);
        check_val("mid_rel_no_wr", XL_wr_en, 0);
        run_cmd(3, 1, 6, 2, 44, 1'b1, 0, 1'b0);

        // Randomized commands, all octants, some near the framebuffer edges.
        for (int n = 0; n < 40; n++) begin
            m = bit'($urandom_range(0, 1));
            near_edge = ($urandom_range(0, 3) == 0);
            bx = near_edge ? $urandom_range(1010, 2030) : $urandom_range(0, 1000);
            by = near_edge ? $urandom_range(750, 1010) : $urandom_range(0, 700);
            ax0 = bx + $urandom_range(0, 12);
            ax1 = bx + $urandom_range(0, 12);
            ay0 = by + $urandom_range(0, 12);
            ay1 = by + $urandom_range(0, 12);
            run_cmd(ax0, ay0, ax1, ay1, $urandom_range(0, 255), m,
                    $urandom_range(0, 2), bit'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
